// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage MULT/DIV unit (shift-add multiply, restoring divide) writing HI/LO.
// Optional signed support is compiled in when MULDIV_SIGNED_EN is defined.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ex_flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic                 is_div_q, is_div_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d, dbz_q, dbz_d;

  logic                 accept_s;
  logic [WIDTH-1:0]     a_mag_s, b_mag_s;
  logic [WIDTH:0]       mul_sum_s, div_shift_s, div_diff_s;
  logic [2*WIDTH-1:0]   step_s;
  logic [WIDTH-1:0]     res_hi_s, res_lo_s;

  assign accept_s = (state_q != S_CALC) && start && !ex_flush && !op[1];

`ifdef MULDIV_SIGNED_EN
  logic neg_q, rem_neg_q;
  logic a_neg_s, b_neg_s;
  assign a_neg_s = sign & a[WIDTH-1];
  assign b_neg_s = sign & b[WIDTH-1];
  assign a_mag_s = a_neg_s ? -a : a;
  assign b_mag_s = b_neg_s ? -b : b;

  // Sign-fixup flags captured when a MULT/DIV is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (accept_s) begin
      neg_q     <= a_neg_s ^ b_neg_s;
      rem_neg_q <= a_neg_s;
    end else begin
      neg_q     <= neg_q;
      rem_neg_q <= rem_neg_q;
    end
  end
`else
  logic unused_sign_s;
  assign unused_sign_s = sign;
  assign a_mag_s = a;
  assign b_mag_s = b;
`endif

  // Multiply: add multiplicand into the upper half when the current multiplier bit is set, then shift right.
  assign mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  // Divide: shift the next dividend bit into the partial remainder and trial-subtract.
  assign div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, opnd_q};

  // One iteration of the selected algorithm.
  always_comb begin
    step_s = '0;
    if (!is_div_q) begin
      step_s = {mul_sum_s, acc_q[WIDTH-1:1]};
    end else if (div_diff_s[WIDTH]) begin
      step_s = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      step_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // Final HI/LO from the last iteration, including sign fix-up and the divide-by-zero override.
  always_comb begin
    res_hi_s = step_s[2*WIDTH-1:WIDTH];
    res_lo_s = step_s[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    if (!is_div_q && neg_q) begin
      {res_hi_s, res_lo_s} = -step_s;
    end else if (is_div_q) begin
      res_lo_s = neg_q     ? -step_s[WIDTH-1:0]       : step_s[WIDTH-1:0];
      res_hi_s = rem_neg_q ? -step_s[2*WIDTH-1:WIDTH] : step_s[2*WIDTH-1:WIDTH];
    end else begin
      res_lo_s = step_s[WIDTH-1:0];
    end
`endif
    if (is_div_q && (opnd_q == '0)) begin
      res_hi_s = a_q;
      res_lo_s = '1;
    end else begin
      res_hi_s = res_hi_s;
    end
  end

  // Next-state, iteration and HI/LO update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start && !ex_flush) begin
          case (op)
            OP_MULT: begin
              state_d  = S_CALC;
              cnt_d    = '0;
              acc_d    = {{WIDTH{1'b0}}, b_mag_s};
              opnd_d   = a_mag_s;
              a_d      = a;
              is_div_d = 1'b0;
            end
            OP_DIV: begin
              state_d  = S_CALC;
              cnt_d    = '0;
              acc_d    = {{WIDTH{1'b0}}, a_mag_s};
              opnd_d   = b_mag_s;
              a_d      = a;
              is_div_d = 1'b1;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (ex_flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_s;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_DONE;
            hi_d    = res_hi_s;
            lo_d    = res_lo_s;
            done_d  = 1'b1;
            dbz_d   = is_div_q && (opnd_q == '0);
          end else begin
            state_d = S_CALC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      a_q      <= a_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == S_CALC);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
